bank_req_queue: RTL
===================

// Module: bank_req_queue
// PURPOSE
//  Per-bank request queue on the requester side of the bank-group arbiter handshake.
//  Buffers scheduled requests from the front end and raises Bank_Req/Valid toward
//  Bank_Group_Fsm. Presents the head request on Data and pops one entry per Ack.
//  Request batching: a queue requests arbitration once THRESH entries are held,
//  or once the oldest entry has waited TIMEOUT cycles.
// PARAMETERS
//  REQ_SIZE  32  width of one request word (addr+index+type+data+valid)
//  DEPTH     16  queue entries; power of two, >=2
//  THRESH    4   occupancy that triggers Bank_Req; 1..DEPTH
//  TIMEOUT   8   max cycles a non-empty queue waits below THRESH; >=1
// PORTS
//  clk       in   1                 rising-edge clock
//  rst_n     in   1                 asynchronous active-low reset
//  in_valid  in   1                 front end offers in_data this cycle
//  in_data   in   REQ_SIZE          request word to enqueue
//  in_ready  out  1                 queue can accept (not full)
//  Bank_Req  out  1                 bank requests arbitration (to Bank_Group_Fsm)
//  Valid     out  1                 head entry present on Data
//  Data      out  REQ_SIZE          head request word; 0 when empty
//  Ack       in   1                 arbiter took head; pop this cycle
//  count     out  $clog2(DEPTH)+1   current occupancy 0..DEPTH
//  err       out  1                 sticky: Ack seen while Valid=0
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - Pointers, count, timer and err clear; FSM goes to IDLE.
//   - Resulting outputs: Bank_Req=0, Valid=0, Data=0, count=0, in_ready=1, err=0.
//   - Reset mid-operation discards all entries; no flush handshake.
//  Storage
//   - DEPTH x REQ_SIZE register array.
//   - wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits; the MSB differs on wrap.
//   - full: ptr LSBs equal and MSBs differ. empty: pointers equal.
//  Push/pop timing
//   - Push when in_valid && in_ready. in_ready = !full (combinational from registered state).
//   - Pop when Ack && Valid. Valid = !empty. Data = empty ? 0 : mem[rd_ptr].
//   - Latency: a word pushed into an empty queue appears on Data/Valid the next cycle.
//     There is no same-cycle bypass.
//   - Push and pop in the same cycle: both occur; count is unchanged.
//   - Full queue: in_ready=0, so no push even if Ack pops that cycle; the slot reopens next cycle.
//   - Ack with Valid=0: ignored (no pointer move); err sets and holds until reset.
//   - Wrap-around: pointers roll modulo 2*DEPTH; behaviour is continuous across wrap.
//  FSM (registered; Bank_Req is decoded from the registered state)
//   - IDLE: Bank_Req=0, timer=0. Goes to WAIT when the queue becomes non-empty.
//   - WAIT: Bank_Req=0; timer increments every cycle.
//     -> REQ when count>=THRESH, or timer==TIMEOUT-1.
//     Both conditions evaluate on next-state count, so the push that reaches THRESH
//     drives Bank_Req=1 on the following cycle.
//   - REQ: Bank_Req=1 and held until the queue is empty.
//     -> IDLE when the pop empties the queue with no simultaneous push.
//     Pushes while in REQ extend the burst.
//   - THRESH==1 degenerates to: Bank_Req=1 one cycle after the first push.
//  Arithmetic
//   - count = wr_ptr - rd_ptr (unsigned, ptr width); never exceeds DEPTH.
//   - timer is $clog2(TIMEOUT)+1 bits and saturates; it is not compared outside WAIT.
// TESTING
//  1. Reset, then push 4 words 0xA0..0xA3 on consecutive cycles.
//     -> Bank_Req=1 the cycle after the 4th push; Data=0xA0; count=4.
//  2. Push 1 word 0x55 only.
//     -> Bank_Req stays 0 for 8 cycles in WAIT, then 1; Ack pops; Bank_Req=0 next cycle.
//  3. Fill 16 words.
//     -> in_ready=0, count=16. Ack plus in_valid in the same cycle: no push; count=15;
//        in_ready=1 next cycle.
//  4. Push 40 words while acking continuously.
//     -> Data order is exactly the push order across two pointer wraps; count never >16.
//  5. Ack with the queue empty.
//     -> no pointer change; err=1 and held; rst_n=0 clears err, count and Bank_Req asynchronously.
//  6. rst_n pulsed low with 6 entries queued.
//     -> count=0, Valid=0, Data=0 immediately; next push behaves as from fresh reset.

Source files
------------

// File: rtl/bank_req_queue.sv
// Per-bank request queue feeding the bank-group arbiter.
// Batches requests by occupancy threshold or head-of-queue timeout.
module bank_req_queue #(
  parameter int REQ_SIZE = 32,
  parameter int DEPTH    = 16,
  parameter int THRESH   = 4,
  parameter int TIMEOUT  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [REQ_SIZE-1:0]      in_data,
  output logic                     in_ready,
  output logic                     Bank_Req,
  output logic                     Valid,
  output logic [REQ_SIZE-1:0]      Data,
  input  logic                     Ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [PW-1:0] THR  = PW'(THRESH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TSAT = '1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REQ
  } state_e;

  logic [REQ_SIZE-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_d;
  logic [TW-1:0] timer_q;
  state_e        state_q;
  logic          err_q;
  logic          full, empty;
  logic          push, pop;

  assign empty = wr_ptr_q == rd_ptr_q;
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
              && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign in_ready = !full;
  assign Valid    = !empty;
  assign push     = in_valid && !full;
  assign pop      = Ack && !empty;

  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);
  assign count_d  = wr_ptr_d - rd_ptr_d;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign Data     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign Bank_Req = state_q == REQ;
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_q | (Ack & empty);
    end
  end

  // Batching decisions look at next-state occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (count_d != '0) begin
            state_q <= (count_d >= THR) ? REQ : WAIT;
          end
        end
        WAIT: begin
          if (count_d == '0) begin
            state_q <= IDLE;
            timer_q <= '0;
          end else if (count_d >= THR || timer_q == TMAX) begin
            state_q <= REQ;
            timer_q <= '0;
          end else if (timer_q != TSAT) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        REQ: begin
          timer_q <= '0;
          if (count_d == '0) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

endmodule
